// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN frame-end types and bus-level constants
// Contents: frame_end_state_t FSM encoding, RECESSIVE/DOMINANT levels,
// default End-of-Frame and Intermission lengths.
package can_pkg;

  typedef enum logic [2:0] {
    FE_IDLE,
    FE_ACK_SLOT,
    FE_ACK_DELIM,
    FE_EOF,
    FE_INTERMISSION
  } frame_end_state_t;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  localparam int DEFAULT_EOF_BITS          = 7;
  localparam int DEFAULT_INTERMISSION_BITS = 3;

endpackage

// File: rtl/frame_end_sequencer_if.sv
// rtl/frame_end_sequencer_if.sv - bit-stream side bundle of the frame-end sequencer
// master: bit-stream processor side (drives enable, sample_point,
//         start_frame_end, is_transmitter, crc_ok, rx_bit, error_detected).
// slave:  frame_end_sequencer (drives tx_bit, ack_slot, eof_in_progress,
//         eof_bit_count, intermission, bus_idle and the four event pulses).
interface frame_end_sequencer_if;

  logic       enable;
  logic       sample_point;
  logic       start_frame_end;
  logic       is_transmitter;
  logic       crc_ok;
  logic       rx_bit;
  logic       error_detected;

  logic       tx_bit;
  logic       ack_slot;
  logic       eof_in_progress;
  logic [2:0] eof_bit_count;
  logic       intermission;
  logic       bus_idle;
  logic       ack_error;
  logic       form_error;
  logic       overload_request;
  logic       sof_detected;

  modport master (
    output enable, sample_point, start_frame_end, is_transmitter, crc_ok,
           rx_bit, error_detected,
    input  tx_bit, ack_slot, eof_in_progress, eof_bit_count, intermission,
           bus_idle, ack_error, form_error, overload_request, sof_detected
  );

  modport slave (
    input  enable, sample_point, start_frame_end, is_transmitter, crc_ok,
           rx_bit, error_detected,
    output tx_bit, ack_slot, eof_in_progress, eof_bit_count, intermission,
           bus_idle, ack_error, form_error, overload_request, sof_detected
  );

endinterface

// File: rtl/frame_end_sequencer.sv
// rtl/frame_end_sequencer.sv - CAN frame tail sequencer (ACK, ACK delim, EOF, Intermission)
// Ports: clock, reset (async, active-high); bus (frame_end_sequencer_if.slave)
// carrying the sample strobe, frame-end start, role/CRC qualifiers and rx level
// in, and the registered bus drive, phase qualifiers and event pulses out.
module frame_end_sequencer
  import can_pkg::*;
#(
  parameter int EOF_BITS          = DEFAULT_EOF_BITS,
  parameter int INTERMISSION_BITS = DEFAULT_INTERMISSION_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  frame_end_sequencer_if.slave bus
);

  localparam logic [2:0] EOF_LAST = 3'(EOF_BITS);
  localparam logic [2:0] IM_LAST  = 3'(INTERMISSION_BITS);

  frame_end_state_t state_q, state_d;
  // One counter serves both EOF and Intermission; only one is ever active.
  logic [2:0] cnt_q, cnt_d;

  logic       tx_bit_q, tx_bit_d;
  logic       ack_slot_q, ack_slot_d;
  logic       eof_q, eof_d;
  logic [2:0] eof_cnt_q, eof_cnt_d;
  logic       inter_q, inter_d;
  logic       idle_q, idle_d;
  logic       ack_err_q, ack_err_d;
  logic       form_err_q, form_err_d;
  logic       ovl_q, ovl_d;
  logic       sof_q, sof_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_err_d  = 1'b0;
    form_err_d = 1'b0;
    ovl_d      = 1'b0;
    sof_d      = 1'b0;

    if (!bus.enable) begin
      state_d = FE_IDLE;
    end else if (state_q != FE_IDLE && bus.error_detected) begin
      // Abort wins over any transition due this cycle and emits no pulse.
      state_d = FE_IDLE;
    end else begin
      case (state_q)
        FE_IDLE: begin
          if (bus.start_frame_end) state_d = FE_ACK_SLOT;
        end
        FE_ACK_SLOT: begin
          if (bus.sample_point) begin
            if (bus.is_transmitter && bus.rx_bit == RECESSIVE) begin
              ack_err_d = 1'b1;
              state_d   = FE_IDLE;
            end else begin
              state_d = FE_ACK_DELIM;
            end
          end
        end
        FE_ACK_DELIM: begin
          if (bus.sample_point) begin
            if (bus.rx_bit == DOMINANT) begin
              form_err_d = 1'b1;
              state_d    = FE_IDLE;
            end else begin
              state_d = FE_EOF;
              cnt_d   = 3'd1;
            end
          end
        end
        FE_EOF: begin
          if (bus.sample_point) begin
            if (bus.rx_bit == DOMINANT) begin
              // A receiver seeing dominant on the last EOF bit starts an
              // overload frame rather than flagging an error.
              if (cnt_q == EOF_LAST && !bus.is_transmitter) ovl_d = 1'b1;
              else                                          form_err_d = 1'b1;
              state_d = FE_IDLE;
            end else if (cnt_q == EOF_LAST) begin
              state_d = FE_INTERMISSION;
              cnt_d   = 3'd1;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        FE_INTERMISSION: begin
          if (bus.sample_point) begin
            if (bus.rx_bit == DOMINANT) begin
              // Dominant on the final intermission bit is taken as the next SOF.
              if (cnt_q == IM_LAST) sof_d = 1'b1;
              else                  ovl_d = 1'b1;
              state_d = FE_IDLE;
            end else if (cnt_q == IM_LAST) begin
              state_d = FE_IDLE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: state_d = FE_IDLE;
      endcase
    end

    if (state_d == FE_IDLE) cnt_d = 3'd0;

    // ACK drive is decided on ACK_SLOT entry and held for the whole slot.
    tx_bit_d = RECESSIVE;
    if (state_d == FE_ACK_SLOT) begin
      if (state_q == FE_ACK_SLOT)                   tx_bit_d = tx_bit_q;
      else if (!bus.is_transmitter && bus.crc_ok)   tx_bit_d = DOMINANT;
    end

    ack_slot_d = (state_d == FE_ACK_SLOT);
    eof_d      = (state_d == FE_EOF);
    eof_cnt_d  = (state_d == FE_EOF) ? cnt_d : 3'd0;
    inter_d    = (state_d == FE_INTERMISSION);
    idle_d     = (state_d == FE_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FE_IDLE;
      cnt_q      <= 3'd0;
      tx_bit_q   <= RECESSIVE;
      ack_slot_q <= 1'b0;
      eof_q      <= 1'b0;
      eof_cnt_q  <= 3'd0;
      inter_q    <= 1'b0;
      idle_q     <= 1'b1;
      ack_err_q  <= 1'b0;
      form_err_q <= 1'b0;
      ovl_q      <= 1'b0;
      sof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_bit_q   <= tx_bit_d;
      ack_slot_q <= ack_slot_d;
      eof_q      <= eof_d;
      eof_cnt_q  <= eof_cnt_d;
      inter_q    <= inter_d;
      idle_q     <= idle_d;
      ack_err_q  <= ack_err_d;
      form_err_q <= form_err_d;
      ovl_q      <= ovl_d;
      sof_q      <= sof_d;
    end
  end

  assign bus.tx_bit           = tx_bit_q;
  assign bus.ack_slot         = ack_slot_q;
  assign bus.eof_in_progress  = eof_q;
  assign bus.eof_bit_count    = eof_cnt_q;
  assign bus.intermission     = inter_q;
  assign bus.bus_idle         = idle_q;
  assign bus.ack_error        = ack_err_q;
  assign bus.form_error       = form_err_q;
  assign bus.overload_request = ovl_q;
  assign bus.sof_detected     = sof_q;

endmodule

// File: tb/tb_frame_end_sequencer.sv
// tb/tb_frame_end_sequencer.sv - self-checking bench for frame_end_sequencer
module tb_frame_end_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  frame_end_sequencer_if bus();

  frame_end_sequencer #(.EOF_BITS(7), .INTERMISSION_BITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // {ack_error, form_error, overload_request, sof_detected}
  localparam logic [3:0] P_ACK  = 4'b1000;
  localparam logic [3:0] P_FORM = 4'b0100;
  localparam logic [3:0] P_OVL  = 4'b0010;
  localparam logic [3:0] P_SOF  = 4'b0001;

  // {tx_bit, ack_slot, eof_in_progress, eof_bit_count[2:0], intermission, bus_idle}
  localparam logic [7:0] ST_IDLE  = 8'b1_0_0_000_0_1;
  localparam logic [7:0] ST_DELIM = 8'b1_0_0_000_0_0;
  localparam logic [7:0] ST_INTER = 8'b1_0_0_000_1_0;

  logic [3:0] exp_q[$];
  logic [7:0] status;
  logic [3:0] pulses;

  assign status = {bus.tx_bit, bus.ack_slot, bus.eof_in_progress, bus.eof_bit_count,
                   bus.intermission, bus.bus_idle};
  assign pulses = {bus.ack_error, bus.form_error, bus.overload_request, bus.sof_detected};

  // Every pulse the DUT emits must match the next expected event.
  always @(negedge clock) begin
    if (!reset && pulses != 4'b0000) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_pulse: got %b required none", pulses);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (pulses !== e) begin
          tests_failed++;
          $display("FAIL pulse: got %b required %b", pulses, e);
        end
      end
    end
  end

  function automatic logic [7:0] eof_st(input int i);
    return {1'b1, 1'b0, 1'b1, 3'(i), 2'b00};
  endfunction

  // One bit time: three idle cycles then a sample point; ends at negedge+1.
  task automatic send_bit(input logic rx);
    bus.rx_bit = rx;
    repeat (3) @(negedge clock);
    bus.sample_point = 1'b1;
    @(negedge clock);
    bus.sample_point = 1'b0;
    #1;
  endtask

  task automatic start_frame(input logic tx, input logic crc);
    bus.is_transmitter  = tx;
    bus.crc_ok          = crc;
    bus.rx_bit          = 1'b1;
    bus.start_frame_end = 1'b1;
    bus.sample_point    = 1'b1;
    @(negedge clock);
    bus.start_frame_end = 1'b0;
    bus.sample_point    = 1'b0;
    #1;
  endtask

  task automatic reach_eof(input logic tx);
    start_frame(tx, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic abort_frame();
    bus.error_detected = 1'b1;
    @(negedge clock);
    bus.error_detected = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL reset_status: got %h required %h", status, ST_IDLE); end
    tests_run++;
    if (pulses !== 4'b0) begin tests_failed++; $display("FAIL reset_pulses: got %b required 0000", pulses); end
    reset = 1'b0;
    @(negedge clock); #1;
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL post_reset_status: got %h required %h", status, ST_IDLE); end
  endtask

  task automatic test_tx_clean();
    start_frame(1'b1, 1'b0);
    tests_run++;
    if (status !== 8'hC0) begin tests_failed++; $display("FAIL tx_ack_slot: got %h required %h", status, 8'hC0); end
    send_bit(1'b0);
    tests_run++;
    if (status !== ST_DELIM) begin tests_failed++; $display("FAIL tx_ack_delim: got %h required %h", status, ST_DELIM); end
    send_bit(1'b1);
    for (int i = 1; i <= 7; i++) begin
      tests_run++;
      if (status !== eof_st(i)) begin tests_failed++; $display("FAIL tx_eof_bit%0d: got %h required %h", i, status, eof_st(i)); end
      send_bit(1'b1);
    end
    for (int j = 1; j <= 3; j++) begin
      tests_run++;
      if (status !== ST_INTER) begin tests_failed++; $display("FAIL tx_intermission%0d: got %h required %h", j, status, ST_INTER); end
      send_bit(1'b1);
    end
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL tx_clean_end: got %h required %h", status, ST_IDLE); end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL tx_clean_events: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_rx_ack();
    logic [1:0] crc_tab;
    crc_tab = 2'b01;
    for (int k = 0; k < 2; k++) begin
      logic       crc;
      logic [7:0] want;
      crc  = crc_tab[k];
      want = {~crc, 1'b1, 6'b000000};
      start_frame(1'b0, crc);
      tests_run++;
      if (status !== want) begin tests_failed++; $display("FAIL rx_ack_crc%0d: got %h required %h", crc, status, want); end
      send_bit(1'b0);
      tests_run++;
      if (status !== ST_DELIM) begin tests_failed++; $display("FAIL rx_ack_release_crc%0d: got %h required %h", crc, status, ST_DELIM); end
      abort_frame();
    end
  endtask

  task automatic test_ack_error();
    start_frame(1'b1, 1'b1);
    exp_q.push_back(P_ACK);
    send_bit(1'b1);
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL ack_error_idle: got %h required %h", status, ST_IDLE); end
    send_bit(1'b1);
    send_bit(1'b1);
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL ack_error_no_eof: got %h required %h", status, ST_IDLE); end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL ack_error_events: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_eof_dominant();
    logic       tx_tab [3] = '{1'b1, 1'b0, 1'b1};
    int         pos_tab[3] = '{4, 7, 7};
    logic [3:0] ev_tab [3] = '{P_FORM, P_OVL, P_FORM};
    for (int k = 0; k < 3; k++) begin
      reach_eof(tx_tab[k]);
      repeat (pos_tab[k] - 1) send_bit(1'b1);
      tests_run++;
      if (status !== eof_st(pos_tab[k])) begin tests_failed++; $display("FAIL eof_reach_case%0d: got %h required %h", k, status, eof_st(pos_tab[k])); end
      exp_q.push_back(ev_tab[k]);
      send_bit(1'b0);
      tests_run++;
      if (status !== ST_IDLE) begin tests_failed++; $display("FAIL eof_dominant_case%0d: got %h required %h", k, status, ST_IDLE); end
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL eof_events_case%0d: got %0d pending required 0", k, exp_q.size()); end
    end
  endtask

  task automatic test_intermission();
    for (int bad = 2; bad <= 3; bad++) begin
      reach_eof(1'b1);
      repeat (7) send_bit(1'b1);
      repeat (bad - 1) send_bit(1'b1);
      tests_run++;
      if (status !== ST_INTER) begin tests_failed++; $display("FAIL inter_reach_bit%0d: got %h required %h", bad, status, ST_INTER); end
      exp_q.push_back(bad == 3 ? P_SOF : P_OVL);
      send_bit(1'b0);
      tests_run++;
      if (status !== ST_IDLE) begin tests_failed++; $display("FAIL inter_dominant_bit%0d: got %h required %h", bad, status, ST_IDLE); end
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL inter_events_bit%0d: got %0d pending required 0", bad, exp_q.size()); end
    end
  endtask

  task automatic test_error_abort();
    reach_eof(1'b1);
    repeat (4) send_bit(1'b1);
    tests_run++;
    if (status !== eof_st(5)) begin tests_failed++; $display("FAIL abort_pre: got %h required %h", status, eof_st(5)); end
    abort_frame();
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL abort_mid_eof: got %h required %h", status, ST_IDLE); end
    // Error coincident with a dominant sample point: abort only, no form error.
    reach_eof(1'b0);
    bus.rx_bit         = 1'b0;
    bus.sample_point   = 1'b1;
    bus.error_detected = 1'b1;
    @(negedge clock);
    bus.sample_point   = 1'b0;
    bus.error_detected = 1'b0;
    bus.rx_bit         = 1'b1;
    #1;
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL abort_priority: got %h required %h", status, ST_IDLE); end
    @(negedge clock); #1;
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL abort_events: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_start_ignored();
    reach_eof(1'b1);
    send_bit(1'b1);
    bus.rx_bit          = 1'b1;
    bus.start_frame_end = 1'b1;
    bus.sample_point    = 1'b1;
    @(negedge clock);
    bus.start_frame_end = 1'b0;
    bus.sample_point    = 1'b0;
    #1;
    tests_run++;
    if (status !== eof_st(3)) begin tests_failed++; $display("FAIL start_ignored: got %h required %h", status, eof_st(3)); end
    abort_frame();
  endtask

  task automatic test_enable();
    reach_eof(1'b1);
    bus.enable = 1'b0;
    @(negedge clock); #1;
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL enable_low: got %h required %h", status, ST_IDLE); end
    bus.enable = 1'b1;
  endtask

  task automatic test_reset_async();
    reach_eof(1'b0);
    repeat (2) send_bit(1'b1);
    tests_run++;
    if (status !== eof_st(3)) begin tests_failed++; $display("FAIL reset_async_pre: got %h required %h", status, eof_st(3)); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (status !== ST_IDLE) begin tests_failed++; $display("FAIL reset_async: got %h required %h", status, ST_IDLE); end
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    bus.enable          = 1'b1;
    bus.sample_point    = 1'b0;
    bus.start_frame_end = 1'b0;
    bus.is_transmitter  = 1'b0;
    bus.crc_ok          = 1'b0;
    bus.rx_bit          = 1'b1;
    bus.error_detected  = 1'b0;

    test_reset();
    test_tx_clean();
    test_rx_ack();
    test_ack_error();
    test_eof_dominant();
    test_intermission();
    test_error_abort();
    test_start_ignored();
    test_enable();
    test_reset_async();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/frame_end_sequencer.md
Name: frame_end_sequencer

Overview:
Drives the tail of every CAN data/remote frame after the CRC delimiter: ACK slot, ACK delimiter, End-of-Frame and Intermission. It produces the `eof_in_progress` / `eof_bit_count` qualifiers consumed by the message validator. It also generates the ACK bit as receiver, and flags ACK, form and overload conditions to the error/overload logic. It sits beside the bit-stream processor and advances one state per sample point.

Parameters:
- EOF_BITS, 7, number of End-of-Frame bits (range 2..7; `eof_bit_count` is 3 bits).
- INTERMISSION_BITS, 3, number of Intermission bits (range 2..3).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  low forces IDLE synchronously and clears all outputs.
- sample_point  input  1  one-cycle strobe at the bit sample point.
- start_frame_end  input  1  one-cycle pulse at the sample point of the CRC delimiter.
- is_transmitter  input  1  node is sending the current frame.
- crc_ok  input  1  receiver CRC matched; qualifies the ACK drive.
- rx_bit  input  1  sampled bus level; 1 = recessive.
- error_detected  input  1  any error from elsewhere; aborts the sequence.
- tx_bit  output  1  bit this block wants on the bus; 1 = recessive.
- ack_slot  output  1  high while in the ACK_SLOT state.
- eof_in_progress  output  1  high while in the EOF state.
- eof_bit_count  output  3  current EOF bit index 1..EOF_BITS; 0 outside EOF.
- intermission  output  1  high while in the INTERMISSION state.
- bus_idle  output  1  high in IDLE when no frame-end is pending.
- ack_error  output  1  one-cycle pulse.
- form_error  output  1  one-cycle pulse.
- overload_request  output  1  one-cycle pulse.
- sof_detected  output  1  one-cycle pulse.

Behaviour:
- Reset and enable low:
  - State IDLE; `tx_bit` = 1; `bus_idle` = 1.
  - All other outputs 0.
  - All outputs registered.
- States: IDLE, ACK_SLOT, ACK_DELIM, EOF, INTERMISSION.
- Transitions occur only on cycles with `sample_point` = 1, except the error abort below.
- IDLE:
  - `start_frame_end` → ACK_SLOT on the next clock.
  - Entering ACK_SLOT: `tx_bit` = 0 if !`is_transmitter` && `crc_ok`, else 1.
- ACK_SLOT, at the sample point:
  - If `is_transmitter` && `rx_bit` = 1: pulse `ack_error` and go to IDLE.
  - Otherwise go to ACK_DELIM with `tx_bit` = 1.
- ACK_DELIM, at the sample point:
  - `rx_bit` = 0: pulse `form_error` and go to IDLE.
  - `rx_bit` = 1: go to EOF with `eof_bit_count` = 1.
- EOF, at the sample point:
  - `rx_bit` = 0 on bits 1..EOF_BITS-1: pulse `form_error` and go to IDLE.
  - Bit EOF_BITS dominant:
    - Receiver: pulse `overload_request`, not an error.
    - Transmitter: pulse `form_error` and go to IDLE.
  - Otherwise increment the count; at EOF_BITS go to INTERMISSION.
  - `eof_bit_count` holds EOF_BITS through the whole last EOF bit, including its sample point, so the validator sees a count of 7 coincident with `sample_point`.
- INTERMISSION, bit counter 1..INTERMISSION_BITS:
  - Dominant on bits 1..N-1: pulse `overload_request`, go to IDLE.
  - Dominant on bit N: pulse `sof_detected`, go to IDLE.
  - All recessive: go to IDLE with `bus_idle` = 1.
- `error_detected` in any non-IDLE state:
  - Go to IDLE on the next clock regardless of `sample_point`.
  - `tx_bit` = 1, `eof_bit_count` = 0, no pulses.
  - Takes priority over a simultaneous transition.
- `start_frame_end` while not in IDLE is ignored.
- `bus_idle` = 0 from ACK_SLOT entry until INTERMISSION completes.
- After an abort, `bus_idle` = 1.
- Error, overload and SOF pulses are exactly one clock wide and mutually exclusive.

Decomposition:
- Shared package `can_pkg`:
  - enum `frame_end_state_t`.
  - Constants RECESSIVE = 1'b1, DOMINANT = 1'b0.
  - Default EOF length 7 and Intermission length 3.
- The module is a single FSM plus one shared 3-bit field counter.
- No sub-module is needed.

Test Plan:
- Transmitter with a clean frame:
  - Stimulus: `start_frame_end`; `rx_bit` = 0 in the ACK slot, 1 everywhere else.
  - Response: `eof_bit_count` steps 1..7 with `eof_in_progress` high, then `intermission` for 3 bits, then `bus_idle` = 1; no pulses.
- Receiver with `crc_ok` = 1:
  - Response: `tx_bit` = 0 for exactly the ACK slot bit, then 1.
  - With `crc_ok` = 0, `tx_bit` stays 1.
- Transmitter with a recessive ACK slot:
  - Response: one-cycle `ack_error`, return to IDLE; EOF is never entered.
- Dominant `rx_bit` at EOF bit 4:
  - Response: `form_error` pulse, `eof_bit_count` → 0, state IDLE.
  - Dominant at bit 7: receiver pulses `overload_request` only; transmitter pulses `form_error`.
- Dominant at Intermission bit 2 → `overload_request`; dominant at bit 3 → `sof_detected`.
- `error_detected` asserted mid-EOF (count = 5) between sample points:
  - Response: next clock IDLE, `tx_bit` = 1, count 0.
  - Asserting `reset` mid-frame gives the same outputs asynchronously.
